ddp_tx_framer: RTL and testbench
================================

DDP_TX_FRAMER -- requirements
Module: ddp_tx_framer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, header FIFO entries (power of two, 2..16).
REQ-002 SHALL provide parameter MSN_INIT, default 32'h0000_0001, MSN value after reset.
REQ-003 SHALL have port clock  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port rdmap2DdpHdrValid  in  1  header strobe from RDMAP header generator.
REQ-006 SHALL have port rdmap2DdpHeader  in  48  RDMAP header; [47:32] STag/queue field, [31:0] offset/length field.
REQ-007 SHALL have port rdmap2DdpCtrl  in  8  RDMAP control byte; bit 7 = tagged message.
REQ-008 SHALL have port ddpTxReady  in  1  downstream accepts a word this cycle.
REQ-009 SHALL have port ddpTxData  out  32  framed DDP header word.
REQ-010 SHALL have port ddpTxValid  out  1  ddpTxData valid.
REQ-011 SHALL have port ddpTxSop / ddpTxEop  out  1 each  first / last word of a frame.
REQ-012 SHALL have port ddpHdrFull  out  1  header FIFO full (registered).
REQ-013 SHALL have port ddpHdrOverflow  out  1  sticky: a header was dropped.

Function
REQ-014 SHALL push {ctrl, header} into the FIFO on rdmap2DdpHdrValid when count < FIFO_DEPTH; otherwise drop it and set ddpHdrOverflow.
REQ-015 SHALL evaluate full from the registered count, so a push while full is dropped even if a pop occurs that cycle.
REQ-016 SHALL run FSM IDLE -> W0 -> W1 -> (W2 if untagged) -> IDLE/W0.
REQ-017 SHALL leave IDLE for W0 on the cycle after the FIFO is non-empty: header on cycle N into empty FIFO gives ddpTxValid at N+1.
REQ-018 SHALL emit W0 = {ctrl[7:0], 8'h01, header[47:32]} with ddpTxSop=1.
REQ-019 SHALL emit W1 = header[31:0]; ddpTxEop=1 when ctrl[7]=1 (tagged, 2-word frame).
REQ-020 SHALL emit W2 = current MSN with ddpTxEop=1 for untagged frames (3-word frame).
REQ-021 SHALL advance only on ddpTxValid && ddpTxReady; data/Sop/Eop held stable while valid and not ready.
REQ-022 SHALL pop the FIFO on the transfer of the Eop word and go straight to W0 if another entry is present (no idle bubble).
REQ-023 SHALL increment MSN by 1 on each W2 transfer, wrapping 32'hFFFF_FFFF -> 0; tagged frames leave MSN unchanged.
REQ-024 SHALL handle simultaneous push and pop in one cycle with count unchanged.

Reset
REQ-025 SHALL on reset: FSM IDLE, FIFO empty, ddpTxValid=0, ddpTxSop=0, ddpTxEop=0, ddpTxData=0, ddpHdrFull=0, ddpHdrOverflow=0, MSN=MSN_INIT.
REQ-026 SHALL on reset mid-frame discard the partial frame and all queued headers; no Eop is emitted for it.
REQ-027 SHALL clear ddpHdrOverflow only by reset.

Configuration
REQ-028 SHALL honour macro DDP_TX_FRAMER_STATS_EN: when defined, add outputs statFrameCnt[15:0] (increments per Eop transfer) and statDropCnt[7:0] (increments per dropped header, saturates at 8'hFF), both reset to 0, statFrameCnt wraps.
REQ-029 SHALL, with DDP_TX_FRAMER_STATS_EN undefined, have neither port nor counter logic; all other behaviour identical.

Structure
REQ-030 SHALL place FSM state encoding, DDP version constant 8'h01, tagged-bit index 7 and MSN width in shared package ddp_pkg.
REQ-031 SHALL implement the header FIFO as one sub-module ddp_hdr_fifo (width 56, depth FIFO_DEPTH, registered count/full/empty).

Verification
REQ-032 SHALL cover: untagged header ctrl=8'h01, hdr=48'h1234_0000_0040, ready=1 -> 3 words 32'h0101_1234, 32'h0000_0040, 32'h0000_0001, Sop on 1st, Eop on 3rd, MSN then 2.
REQ-033 SHALL cover: tagged ctrl=8'h80 -> 2 words, Eop on W1, MSN unchanged.
REQ-034 SHALL cover: 5 back-to-back headers with ready=0 (depth 4) -> ddpHdrFull=1 after 4th, 5th dropped, ddpHdrOverflow=1, later 4 frames out with no idle cycles between.
REQ-035 SHALL cover: ready toggled 1/0 each cycle -> ddpTxData/Sop/Eop stable while stalled, word order intact.
REQ-036 SHALL cover: MSN preloaded to 32'hFFFF_FFFF (MSN_INIT) -> untagged frame emits FFFF_FFFF, next emits 0.
REQ-037 SHALL cover: reset asserted during W1 -> outputs at reset values same cycle, next header yields fresh frame with MSN=MSN_INIT.

Source files
------------

// File: rtl/ddp_pkg.sv
// ddp_pkg: shared DDP framer constants, FSM state encoding and FIFO entry layout.
package ddp_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W0   = 2'd1,
    ST_W1   = 2'd2,
    ST_W2   = 2'd3
  } state_t;
  localparam logic [7:0] DDP_VER = 8'h01;
  localparam int TAG_BIT = 7;
  localparam int MSN_W = 32;
  localparam int HDR_W = 48;
  localparam int CTRL_W = 8;
  localparam int ENTRY_W = CTRL_W + HDR_W;
endpackage

// File: rtl/ddp_hdr_fifo.sv
// ddp_hdr_fifo: header FIFO with registered count/full/empty; pushes while full are dropped.
module ddp_hdr_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_full, r_empty;
  logic             w_push, w_pop;
  assign w_push = i_push && !r_full;
  assign w_pop = i_pop && !r_empty;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      r_full <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
  assign o_data = r_mem[r_rd_ptr];
  assign o_full = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_drop = i_push && r_full;
endmodule

// File: rtl/ddp_tx_framer.sv
// ddp_tx_framer: queues RDMAP headers and emits 2-word (tagged) or 3-word (untagged) DDP header frames.
// Optional statistics counters are enabled by defining DDP_TX_FRAMER_STATS_EN.
module ddp_tx_framer
  import ddp_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [MSN_W-1:0] MSN_INIT   = 32'h0000_0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rdmap2DdpHdrValid,
  input  logic [HDR_W-1:0]  rdmap2DdpHeader,
  input  logic [CTRL_W-1:0] rdmap2DdpCtrl,
  input  logic              ddpTxReady,
  output logic [31:0]       ddpTxData,
  output logic              ddpTxValid,
  output logic              ddpTxSop,
  output logic              ddpTxEop,
  output logic              ddpHdrFull,
  output logic              ddpHdrOverflow
`ifdef DDP_TX_FRAMER_STATS_EN
  ,
  output logic [15:0]       statFrameCnt,
  output logic [7:0]        statDropCnt
`endif
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  state_t             r_state, w_state_nxt;
  logic [MSN_W-1:0]   r_msn;
  logic               r_ovf;
  logic [ENTRY_W-1:0] w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full, w_empty, w_drop, w_pop;
  logic               w_push_ok, w_xfer, w_more, w_tagged;
  logic [CTRL_W-1:0]  w_ctrl;
  logic [HDR_W-1:0]   w_hdr;
  ddp_hdr_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (rdmap2DdpHdrValid),
    .i_data  ({rdmap2DdpCtrl, rdmap2DdpHeader}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );
  assign w_ctrl = w_head[ENTRY_W-1:HDR_W];
  assign w_hdr = w_head[HDR_W-1:0];
  assign w_tagged = w_ctrl[TAG_BIT];
  assign w_push_ok = rdmap2DdpHdrValid && !w_full;
  assign w_xfer = ddpTxValid && ddpTxReady;
  // Another header is available after this pop, either already queued or arriving now.
  assign w_more = w_push_ok || (w_count > CNT_W'(1));
  always_comb begin
    w_state_nxt = r_state;
    ddpTxValid = 1'b0;
    ddpTxSop = 1'b0;
    ddpTxEop = 1'b0;
    ddpTxData = '0;
    unique case (r_state)
      ST_IDLE: w_state_nxt = (!w_empty || w_push_ok) ? ST_W0 : ST_IDLE;
      ST_W0: begin
        ddpTxValid = 1'b1;
        ddpTxSop = 1'b1;
        ddpTxData = {w_ctrl, DDP_VER, w_hdr[47:32]};
        if (w_xfer) w_state_nxt = ST_W1;
      end
      ST_W1: begin
        ddpTxValid = 1'b1;
        ddpTxEop = w_tagged;
        ddpTxData = w_hdr[31:0];
        if (w_xfer) w_state_nxt = w_tagged ? (w_more ? ST_W0 : ST_IDLE) : ST_W2;
      end
      ST_W2: begin
        ddpTxValid = 1'b1;
        ddpTxEop = 1'b1;
        ddpTxData = r_msn;
        if (w_xfer) w_state_nxt = w_more ? ST_W0 : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_pop = w_xfer && ddpTxEop;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_msn <= MSN_INIT;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer && r_state == ST_W2) r_msn <= r_msn + MSN_W'(1);
      if (w_drop) r_ovf <= 1'b1;
    end
  end
  assign ddpHdrFull = w_full;
  assign ddpHdrOverflow = r_ovf;
`ifdef DDP_TX_FRAMER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_drop_cnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
  assign statFrameCnt = r_frame_cnt;
  assign statDropCnt = r_drop_cnt;
`endif
endmodule

// File: tb/tb_ddp_tx_framer.sv
// tb_ddp_tx_framer: directed self-checking bench for ddp_tx_framer (default and wrapped-MSN instances).
module tb_ddp_tx_framer;
  logic        clock = 1'b0;
  logic        reset;
  logic        hv;
  logic [47:0] hdr;
  logic [7:0]  ctrl;
  logic        ready;
  logic [31:0] data1, data2;
  logic        valid1, sop1, eop1, full1, ovf1;
  logic        valid2, sop2, eop2, full2, ovf2;
  int total = 0;
  int bad = 0;
  logic [31:0] w5 [3];
  int k;
  always #5 clock = ~clock;
  ddp_tx_framer u_dut (
    .clock(clock), .reset(reset), .rdmap2DdpHdrValid(hv), .rdmap2DdpHeader(hdr),
    .rdmap2DdpCtrl(ctrl), .ddpTxReady(ready), .ddpTxData(data1), .ddpTxValid(valid1),
    .ddpTxSop(sop1), .ddpTxEop(eop1), .ddpHdrFull(full1), .ddpHdrOverflow(ovf1)
  );
  ddp_tx_framer #(.MSN_INIT(32'hFFFF_FFFF)) u_dut2 (
    .clock(clock), .reset(reset), .rdmap2DdpHdrValid(hv), .rdmap2DdpHeader(hdr),
    .rdmap2DdpCtrl(ctrl), .ddpTxReady(ready), .ddpTxData(data2), .ddpTxValid(valid2),
    .ddpTxSop(sop2), .ddpTxEop(eop2), .ddpHdrFull(full2), .ddpHdrOverflow(ovf2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_word(input string tag, input logic [31:0] d, input logic s, input logic e);
    chk({tag, "_valid"}, 32'(valid1), 32'd1);
    chk({tag, "_data"}, data1, d);
    chk({tag, "_sop"}, 32'(sop1), 32'(s));
    chk({tag, "_eop"}, 32'(eop1), 32'(e));
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [7:0] c, input logic [47:0] h);
    hv = 1'b1;
    ctrl = c;
    hdr = h;
    tick();
    hv = 1'b0;
  endtask
  initial begin
    reset = 1'b1; hv = 1'b0; hdr = '0; ctrl = '0; ready = 1'b1;
    #1;
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_sop", 32'(sop1), 32'd0);
    chk("rst_eop", 32'(eop1), 32'd0);
    chk("rst_data", data1, 32'd0);
    chk("rst_full", 32'(full1), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_valid", 32'(valid1), 32'd0);
    // untagged frame, ready held high
    push(8'h01, 48'h1234_0000_0040);
    chk_word("t1w0", 32'h0101_1234, 1'b1, 1'b0); tick();
    chk_word("t1w1", 32'h0000_0040, 1'b0, 1'b0); tick();
    chk_word("t1w2", 32'h0000_0001, 1'b0, 1'b1); tick();
    chk("t1_idle", 32'(valid1), 32'd0);
    // tagged frame: two words, MSN untouched
    push(8'h80, 48'hABCD_1111_2222);
    chk_word("t2w0", 32'h8001_ABCD, 1'b1, 1'b0); tick();
    chk_word("t2w1", 32'h1111_2222, 1'b0, 1'b1); tick();
    chk("t2_idle", 32'(valid1), 32'd0);
    push(8'h01, 48'h5555_0000_0008);
    chk_word("t3w0", 32'h0101_5555, 1'b1, 1'b0); tick();
    chk_word("t3w1", 32'h0000_0008, 1'b0, 1'b0); tick();
    chk_word("t3w2", 32'h0000_0002, 1'b0, 1'b1); tick();
    chk("t3_idle", 32'(valid1), 32'd0);
    // fill the FIFO while stalled, fifth header is dropped
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hv = 1'b1;
      ctrl = 8'h80;
      hdr = {16'hA000 + 16'(i), 32'(i)};
      tick();
      if (i == 2) chk("t4_notfull", 32'(full1), 32'd0);
      if (i == 3) begin
        chk("t4_full", 32'(full1), 32'd1);
        chk("t4_noovf", 32'(ovf1), 32'd0);
      end
    end
    hv = 1'b0;
    chk("t4_full2", 32'(full1), 32'd1);
    chk("t4_ovf", 32'(ovf1), 32'd1);
    chk_word("t4_stall", 32'h8001_A000, 1'b1, 1'b0);
    tick();
    chk_word("t4_stall2", 32'h8001_A000, 1'b1, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_word("t4w0", {16'h8001, 16'hA000 + 16'(i)}, 1'b1, 1'b0); tick();
      chk_word("t4w1", 32'(i), 1'b0, 1'b1); tick();
    end
    chk("t4_idle", 32'(valid1), 32'd0);
    chk("t4_empty", 32'(full1), 32'd0);
    chk("t4_ovf_sticky", 32'(ovf1), 32'd1);
    // ready toggling: outputs hold while stalled
    ready = 1'b0;
    push(8'h01, 48'h7777_0000_0010);
    w5[0] = 32'h0101_7777; w5[1] = 32'h0000_0010; w5[2] = 32'h0000_0003;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      chk_word("t5", w5[k], k == 0, k == 2);
      ready = (c % 2) == 1;
      tick();
      if (ready) k++;
    end
    chk("t5_idle", 32'(valid1), 32'd0);
    ready = 1'b1;
    // MSN wrap on the preloaded instance
    reset = 1'b1; tick(); reset = 1'b0; tick();
    push(8'h01, 48'h9999_0000_0050); tick(); tick();
    chk("t6_u2_msn", data2, 32'hFFFF_FFFF);
    chk("t6_u2_eop", 32'(eop2), 32'd1);
    chk("t6_u1_msn", data1, 32'h0000_0001);
    tick();
    push(8'h01, 48'h9999_0000_0050); tick(); tick();
    chk("t6_u2_wrap", data2, 32'h0000_0000);
    chk("t6_u1_msn2", data1, 32'h0000_0002);
    tick();
    // reset during W1 with a second header queued
    push(8'h01, 48'h2222_0000_0020);
    hv = 1'b1; ctrl = 8'h01; hdr = 48'h4444_0000_0040;
    tick();
    hv = 1'b0;
    chk_word("t7w1", 32'h0000_0020, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t7_valid", 32'(valid1), 32'd0);
    chk("t7_sop", 32'(sop1), 32'd0);
    chk("t7_eop", 32'(eop1), 32'd0);
    chk("t7_data", data1, 32'd0);
    chk("t7_full", 32'(full1), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("t7_flushed", 32'(valid1), 32'd0);
    push(8'h01, 48'h3333_0000_0030);
    chk_word("t7f0", 32'h0101_3333, 1'b1, 1'b0); tick();
    chk_word("t7f1", 32'h0000_0030, 1'b0, 1'b0); tick();
    chk_word("t7f2", 32'h0000_0001, 1'b0, 1'b1); tick();
    chk("t7_idle", 32'(valid1), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
